// File: rtl/cifra_render.sv
// Numeric debug overlay: captures a 13-bit magnitude plus sign on each YO change, converts it to
// BCD with a sequential double-dabble, and paints "sdddd" as 8x16 cells just below the YO row.
// state | meaning
// IDLE  | no conversion running
// SHIFT | double-dabble iterations, 13 cycles
// DONE  | commit digits/sign/row to the display registers
module cifra_render #(
    parameter int               PIX_W   = 8,
    parameter int               X0      = 16,
    parameter int               ROW_OFS = 1,
    parameter logic [PIX_W-1:0] FG      = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_in,
    input  logic [10:0]      X,
    input  logic [10:0]      Y,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [12:0]      cifra,
    input  logic             znak,
    input  logic [10:0]      YO,
    output logic [PIX_W-1:0] pix_out,
    output logic             de_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] GL_MINUS = 4'd10;
    localparam logic [3:0] GL_BLANK = 4'd15;

    state_t      state, state_nxt;
    logic [10:0] yo_prev;
    logic        cap;
    logic [3:0]  iter;
    logic [28:0] dd;
    logic        sh_sign;
    logic [10:0] sh_yo;

    logic        disp_valid;
    logic [15:0] disp_bcd;
    logic        disp_sign;
    logic [10:0] disp_yo;

    // One double-dabble iteration on {bcd[15:0], bin[12:0]}: add-3 correction, then shift left.
    function automatic logic [28:0] dabble_step(input logic [28:0] s);
        logic [28:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[13+4*i +: 4] >= 4'd5)
                t[13+4*i +: 4] = t[13+4*i +: 4] + 4'd3;
        end
        return {t[27:0], 1'b0};
    endfunction

    // 5x7 font, row 0 in the top bits, leftmost column is the MSB of each row.
    function automatic logic [34:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1:    glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
            4'd10:   glyph = 35'b00000_00000_00000_11111_00000_00000_00000;
            default: glyph = '0;
        endcase
    endfunction

    assign cap  = (YO != yo_prev);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            SHIFT:   if (iter == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A new value always (re)starts the conversion, including from DONE.
        if (cap) state_nxt = SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yo_prev <= '0;
            iter    <= '0;
            dd      <= '0;
            sh_sign <= 1'b0;
            sh_yo   <= '0;
        end else begin
            yo_prev <= YO;
            if (cap) begin
                dd      <= {16'd0, cifra};
                sh_sign <= znak;
                sh_yo   <= YO;
                iter    <= 4'd12;
            end else if (state == SHIFT) begin
                dd <= dabble_step(dd);
                if (iter != 4'd0) iter <= iter - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid <= 1'b0;
            disp_bcd   <= '0;
            disp_sign  <= 1'b0;
            disp_yo    <= '0;
        end else if (state == DONE) begin
            disp_valid <= 1'b1;
            disp_bcd   <= dd[28:13];
            disp_sign  <= sh_sign;
            disp_yo    <= sh_yo;
        end
    end

    logic [11:0] band_base, dy, dx;
    logic        in_band, in_field;
    logic        lz3, lz2, lz1;
    logic [3:0]  cell_code;

    // 12-bit arithmetic so that band rows past 2047 never match an 11-bit Y.
    always_comb begin
        band_base = {1'b0, disp_yo} + 12'(ROW_OFS);
        dy        = {1'b0, Y} - band_base;
        in_band   = ({1'b0, Y} >= band_base) && (dy < 12'd16);
        dx        = {1'b0, X} - 12'(X0);
        in_field  = ({1'b0, X} >= 12'(X0)) && (dx < 12'd40);
        lz3       = (disp_bcd[15:12] == 4'd0);
        lz2       = lz3 && (disp_bcd[11:8] == 4'd0);
        lz1       = lz2 && (disp_bcd[7:4] == 4'd0);
        case (dx[5:3])
            3'd0:    cell_code = disp_sign ? GL_MINUS : GL_BLANK;
            3'd1:    cell_code = lz3 ? GL_BLANK : disp_bcd[15:12];
            3'd2:    cell_code = lz2 ? GL_BLANK : disp_bcd[11:8];
            3'd3:    cell_code = lz1 ? GL_BLANK : disp_bcd[7:4];
            3'd4:    cell_code = disp_bcd[3:0];
            default: cell_code = GL_BLANK;
        endcase
    end

    logic             s1_de, s1_hit;
    logic [PIX_W-1:0] s1_pix;
    logic [3:0]       s1_code, s1_r;
    logic [2:0]       s1_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de   <= 1'b0;
            s1_hit  <= 1'b0;
            s1_pix  <= '0;
            s1_code <= GL_BLANK;
            s1_r    <= '0;
            s1_c    <= '0;
        end else begin
            s1_de   <= de_in;
            s1_hit  <= de_in && disp_valid && in_band && in_field;
            s1_pix  <= pix_in;
            s1_code <= cell_code;
            s1_r    <= dy[3:0];
            s1_c    <= dx[2:0];
        end
    end

    logic [34:0] g;
    logic [4:0]  row_bits;
    logic        lit;

    // Each glyph row is drawn on two lines; cell row 0/15 and columns 0/6/7 are spacing.
    always_comb begin
        g = glyph(s1_code);
        case (s1_r)
            4'd1,  4'd2:  row_bits = g[34:30];
            4'd3,  4'd4:  row_bits = g[29:25];
            4'd5,  4'd6:  row_bits = g[24:20];
            4'd7,  4'd8:  row_bits = g[19:15];
            4'd9,  4'd10: row_bits = g[14:10];
            4'd11, 4'd12: row_bits = g[9:5];
            4'd13, 4'd14: row_bits = g[4:0];
            default:      row_bits = '0;
        endcase
        case (s1_c)
            3'd1:    lit = row_bits[4];
            3'd2:    lit = row_bits[3];
            3'd3:    lit = row_bits[2];
            3'd4:    lit = row_bits[1];
            3'd5:    lit = row_bits[0];
            default: lit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out <= '0;
            de_out  <= 1'b0;
        end else begin
            pix_out <= (s1_hit && lit) ? FG : s1_pix;
            de_out  <= s1_de;
        end
    end

endmodule

// File: tb/tb_cifra_render.sv
// Self-checking bench for cifra_render: every pixel, de_out and busy is compared against a
// cycle-level reference that renders the text field from decimal arithmetic and a font table.
module tb_cifra_render;

    logic        clk = 1'b0;
    logic        rst, de_in, znak;
    logic [10:0] X, Y, YO;
    logic [7:0]  pix_in;
    logic [12:0] cifra;
    logic [7:0]  pix_out;
    logic        de_out, busy;

    cifra_render dut (
        .clk(clk), .rst(rst), .de_in(de_in), .X(X), .Y(Y), .pix_in(pix_in),
        .cifra(cifra), .znak(znak), .YO(YO),
        .pix_out(pix_out), .de_out(de_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [12:0] val;
        logic        sgn;
        logic [10:0] yo;
        logic [39:0] text;
    } vec_t;
    vec_t tbl [8];

    typedef struct packed {
        logic [7:0] pix;
        logic       de;
    } oexp_t;
    oexp_t q[$];

    // reference display state
    bit          m_pend, m_valid, m_busy;
    int          m_left;
    logic [19:0] m_pcodes, m_dcodes, next_codes;
    int          m_pyo, m_dyo;
    logic [10:0] m_prev;
    int          run_len, last_run;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] font_row(input int code, input int row);
        logic [34:0] f;
        case (code)
            0:  f = 35'b01110_10001_10011_10101_11001_10001_01110;
            1:  f = 35'b00100_01100_00100_00100_00100_00100_01110;
            2:  f = 35'b01110_10001_00001_00010_00100_01000_11111;
            3:  f = 35'b11111_00010_00100_00010_00001_10001_01110;
            4:  f = 35'b00010_00110_01010_10010_11111_00010_00010;
            5:  f = 35'b11111_10000_11110_00001_00001_10001_01110;
            6:  f = 35'b00110_01000_10000_11110_10001_10001_01110;
            7:  f = 35'b11111_00001_00010_00100_01000_01000_01000;
            8:  f = 35'b01110_10001_10001_01110_10001_10001_01110;
            9:  f = 35'b01110_10001_10001_01111_00001_00010_01100;
            10: f = 35'b00000_00000_00000_11111_00000_00000_00000;
            default: f = '0;
        endcase
        return f[34-5*row -: 5];
    endfunction

    // Cell codes: 0-9 digit, 10 minus, 15 blank; cell k in bits [4k+3:4k].
    function automatic logic [19:0] codes_of(input int val, input bit sgn);
        logic [19:0] c;
        int p;
        c[3:0] = sgn ? 4'd10 : 4'd15;
        p = 1000;
        for (int k = 1; k <= 4; k++) begin
            if (val >= p || k == 4) c[4*k +: 4] = 4'((val / p) % 10);
            else                    c[4*k +: 4] = 4'd15;
            p = p / 10;
        end
        return c;
    endfunction

    function automatic logic [19:0] text_codes(input logic [39:0] t);
        logic [19:0] c;
        logic [7:0]  ch;
        for (int k = 0; k < 5; k++) begin
            ch = t[39-8*k -: 8];
            if (ch == " ")      c[4*k +: 4] = 4'd15;
            else if (ch == "-") c[4*k +: 4] = 4'd10;
            else                c[4*k +: 4] = 4'(ch - "0");
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_px(input int x, input int y, input bit de, input logic [7:0] pix);
        int base, r, dx, k, c, code;
        logic [4:0] rb;
        if (!de || !m_valid) return pix;
        base = m_dyo + 1;
        r = y - base;
        dx = x - 16;
        if (r < 0 || r > 15 || dx < 0 || dx >= 40) return pix;
        k = dx / 8;
        c = dx % 8;
        if (r < 1 || r > 14 || c < 1 || c > 5) return pix;
        code = int'(m_dcodes[4*k +: 4]);
        if (code > 10) return pix;
        rb = font_row(code, (r - 1) / 2);
        return rb[5-c] ? 8'hFF : pix;
    endfunction

    // Latency view: a capture on edge E is shown from edge E+14 onwards; busy is high in between.
    function automatic void m_edge(input bit r);
        if (r) begin
            m_pend = 0; m_valid = 0; m_prev = '0; m_busy = 0;
        end else begin
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1; m_dcodes = m_pcodes; m_dyo = m_pyo; m_pend = 0;
                end
            end
            if (YO != m_prev) begin
                m_pend = 1; m_left = 14; m_pcodes = next_codes; m_pyo = int'(YO);
            end
            m_prev = YO;
            m_busy = m_pend;
        end
    endfunction

    task automatic step(input bit r, input logic [10:0] x, input logic [10:0] y, input bit de,
                        input logic [7:0] pix);
        oexp_t e;
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("pix_out", {24'd0, pix_out}, {24'd0, e.pix});
            chk("de_out", {31'd0, de_out}, {31'd0, e.de});
        end
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        if (busy === 1'b1) run_len++;
        else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
        rst = r; X = x; Y = y; de_in = de; pix_in = pix;
        if (r) foreach (q[i]) q[i] = '0;
        e.pix = r ? 8'h00 : exp_px(int'(x), int'(y), de, pix);
        e.de  = r ? 1'b0 : de;
        q.push_back(e);
        m_edge(r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 11'($urandom_range(0, 63)), 11'((m_dyo + int'($urandom_range(0, 18))) % 2048),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    task automatic capture(input logic [10:0] yo, input logic [12:0] val, input bit sgn,
                           input logic [19:0] codes);
        YO = yo; cifra = val; znak = sgn; next_codes = codes;
        last_run = -1;
        idle(1);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (busy === 1'b1 && g < 60) begin
            idle(1);
            g++;
        end
        idle(1);
    endtask

    task automatic sweep(input int yo, input int rows);
        for (int i = 0; i < rows; i++)
            for (int x = 14; x <= 57; x++)
                step(0, 11'(x), 11'((yo + i) % 2048), ($urandom_range(0, 7) != 0),
                     8'($urandom_range(0, 255)));
    endtask

    initial begin
        int val, yo;
        bit sgn;
        tbl[0] = '{13'd1234, 1'b0, 11'h040, " 1234"};
        tbl[1] = '{13'd7,    1'b1, 11'h060, "-   7"};
        tbl[2] = '{13'd0,    1'b0, 11'h070, "    0"};
        tbl[3] = '{13'd8191, 1'b0, 11'h100, " 8191"};
        tbl[4] = '{13'd1000, 1'b1, 11'h200, "-1000"};
        tbl[5] = '{13'd305,  1'b0, 11'h300, "  305"};
        tbl[6] = '{13'd90,   1'b1, 11'h7F8, "-  90"};
        tbl[7] = '{13'd10,   1'b0, 11'h010, "   10"};

        rst = 1'b1; de_in = 1'b1; X = 11'd20; Y = 11'h041; pix_in = 8'h10;
        YO = '0; cifra = '0; znak = 1'b0; next_codes = '0;
        m_pend = 0; m_valid = 0; m_busy = 0; m_left = 0; m_prev = '0;
        m_pcodes = '0; m_dcodes = '0; m_pyo = 0; m_dyo = 0; run_len = 0; last_run = -1;
        @(negedge clk);

        // reset: outputs held low, then plain 2-cycle pass-through
        for (int i = 0; i < 5; i++) step(1, 11'd20 + 11'(i), 11'h041, 1'b1, 8'h10);
        for (int i = 0; i < 6; i++) step(0, 11'd20 + 11'(i), 11'h041, 1'b1, 8'h10);

        // table-driven values
        foreach (tbl[i]) begin
            capture(tbl[i].yo, tbl[i].val, tbl[i].sgn, text_codes(tbl[i].text));
            wait_done();
            chk("busy_len", last_run, 14);
            sweep(int'(tbl[i].yo), 18);
        end

        // abort: 5000 replaced by 42 five cycles later, never committed
        capture(11'h080, 13'd5000, 1'b0, text_codes(" 5000"));
        idle(4);
        capture(11'h0A0, 13'd42, 1'b0, text_codes("   42"));
        wait_done();
        chk("busy_len_abort", last_run, 19);
        sweep(32'h080, 18);
        sweep(32'h0A0, 18);

        // capture in the same cycle as DONE: first value commits, second follows
        capture(11'h400, 13'd321, 1'b0, text_codes("  321"));
        idle(13);
        capture(11'h402, 13'd6789, 1'b1, text_codes("-6789"));
        sweep(32'h400, 20);
        chk("busy_len_done_cap", last_run, 28);

        // reset six cycles into a conversion
        capture(11'h0C0, 13'd99, 1'b0, text_codes("   99"));
        idle(5);
        YO = '0;
        step(1, 11'd0, 11'd0, 1'b0, 8'h00);
        chk("busy_after_rst", {31'd0, busy}, 32'd0);
        sweep(32'h0C0, 18);
        capture(11'h0C0, 13'd99, 1'b0, text_codes("   99"));
        wait_done();
        chk("busy_len_after_rst", last_run, 14);
        sweep(32'h0C0, 18);

        // randomized values, some aborted mid-conversion
        for (int n = 0; n < 15; n++) begin
            val = int'($urandom_range(0, 8191));
            sgn = 1'($urandom_range(0, 1));
            yo  = int'($urandom_range(0, 2047));
            if (11'(yo) == YO) yo = yo ^ 1;
            capture(11'(yo), 13'(val), sgn, codes_of(val, sgn));
            if ($urandom_range(0, 2) == 0) begin
                idle(int'($urandom_range(0, 14)));
                val = int'($urandom_range(0, 8191));
                sgn = 1'($urandom_range(0, 1));
                yo  = (yo + int'($urandom_range(1, 2000))) % 2048;
                capture(11'(yo), 13'(val), sgn, codes_of(val, sgn));
            end
            wait_done();
            sweep(yo, 18);
        end

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
